// File: rtl/algo_yuv422_to_yuv444_p.sv
// YUV 4:2:2 -> 4:4:4 upsampler: {Y,C} beats in, {Y,Cb,Cr} pixels out at a fixed
// four-cycle latency, with optional linear chroma interpolation on odd pixels.
module algo_yuv422_to_yuv444_p #(
    parameter int DW       = 8,
    parameter int Y_UPPER  = 1,
    parameter int CB_FIRST = 1,
    parameter int INTERP   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_vs,
    input  logic            i_hs,
    input  logic            i_data_en,
    input  logic [2*DW-1:0] i_q,
    output logic [DW-1:0]   o_y,
    output logic [DW-1:0]   o_cb,
    output logic [DW-1:0]   o_cr,
    output logic            o_vs,
    output logic            o_hs,
    output logic            o_data_en
);

    localparam logic [DW-1:0] C_MID = {1'b1, {(DW-1){1'b0}}};

    logic          phase_in;
    logic [DW-1:0] in_y;
    logic [DW-1:0] in_c;

    // index 0 holds beat n+2, index 2 holds beat n (the one being emitted)
    logic [2:0]    st_valid;
    logic [2:0]    st_phase;
    logic [2:0]    st_vs;
    logic [2:0]    st_hs;
    logic [DW-1:0] st_y [0:2];
    logic [DW-1:0] st_c [0:2];

    logic [DW-1:0] first_hold;
    logic [DW-1:0] sec_hold;
    logic          sec_valid;

    logic          partner;
    logic          next_pair;
    logic [DW-1:0] pix_first;
    logic [DW-1:0] pix_second;

    function automatic logic [DW-1:0] avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, 1'b1};
        sum = sum >> 1;
        return sum[DW-1:0];
    endfunction

    assign in_y = (Y_UPPER != 0) ? i_q[2*DW-1:DW] : i_q[DW-1:0];
    assign in_c = (Y_UPPER != 0) ? i_q[DW-1:0]    : i_q[2*DW-1:DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_in <= 1'b0;
            st_valid <= '0;
            st_phase <= '0;
            st_vs    <= '0;
            st_hs    <= '0;
            for (int i = 0; i < 3; i++) begin
                st_y[i] <= '0;
                st_c[i] <= '0;
            end
        end else begin
            phase_in <= i_data_en ? ~phase_in : 1'b0;
            st_valid <= {st_valid[1:0], i_data_en};
            st_phase <= {st_phase[1:0], phase_in & i_data_en};
            st_vs    <= {st_vs[1:0], i_vs};
            st_hs    <= {st_hs[1:0], i_hs};
            st_y[0]  <= in_y;
            st_c[0]  <= in_c;
            for (int i = 1; i < 3; i++) begin
                st_y[i] <= st_y[i-1];
                st_c[i] <= st_c[i-1];
            end
        end
    end

    // a phase restart or an invalid beat marks a line boundary
    assign partner   = st_valid[1] & st_phase[1];
    assign next_pair = st_valid[1] & ~st_phase[1] & st_valid[0] & st_phase[0];

    always_comb begin
        pix_first  = st_c[2];
        pix_second = st_c[1];
        if (!st_phase[2]) begin
            if (partner) begin
                pix_second = st_c[1];
            end else if (sec_valid) begin
                pix_second = sec_hold;
            end else begin
                pix_second = C_MID;
            end
        end else if ((INTERP != 0) && next_pair) begin
            pix_first  = avg(first_hold, st_c[1]);
            pix_second = avg(st_c[2], st_c[0]);
        end else begin
            pix_first  = first_hold;
            pix_second = st_c[2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_y        <= '0;
            o_cb       <= '0;
            o_cr       <= '0;
            o_vs       <= 1'b0;
            o_hs       <= 1'b0;
            o_data_en  <= 1'b0;
            first_hold <= '0;
            sec_hold   <= '0;
            sec_valid  <= 1'b0;
        end else begin
            o_vs      <= st_vs[2];
            o_hs      <= st_hs[2];
            o_data_en <= st_valid[2];
            if (st_valid[2]) begin
                o_y  <= st_y[2];
                o_cb <= (CB_FIRST != 0) ? pix_first  : pix_second;
                o_cr <= (CB_FIRST != 0) ? pix_second : pix_first;
                if (!st_phase[2]) begin
                    first_hold <= st_c[2];
                end else begin
                    sec_hold  <= st_c[2];
                    sec_valid <= 1'b1;
                end
            end else begin
                sec_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_algo_yuv422_to_yuv444_p.sv
// Directed bench: three upsampler configurations driven from one beat stream,
// outputs captured per pixel and compared against hand-computed tables.
module tb_algo_yuv422_to_yuv444_p;

    logic        clk;
    logic        rst;
    logic        i_vs;
    logic        i_hs;
    logic        i_data_en;
    logic [15:0] i_q;
    logic [19:0] i_q10;

    logic [7:0] rep_y, rep_cb, rep_cr;
    logic       rep_vs, rep_hs, rep_de;
    logic [7:0] int_y, int_cb, int_cr;
    logic       int_vs, int_hs, int_de;
    logic [9:0] w10_y, w10_cb, w10_cr;
    logic       w10_vs, w10_hs, w10_de;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [23:0] rep_q[$];
    logic [23:0] int_q[$];
    logic [29:0] w10_q[$];
    int          rep_cyc[$];
    logic [1:0]  rep_sync[$];

    algo_yuv422_to_yuv444_p #(.DW(8), .Y_UPPER(1), .CB_FIRST(1), .INTERP(0)) u_rep (
        .clk(clk), .rst(rst), .i_vs(i_vs), .i_hs(i_hs), .i_data_en(i_data_en), .i_q(i_q),
        .o_y(rep_y), .o_cb(rep_cb), .o_cr(rep_cr), .o_vs(rep_vs), .o_hs(rep_hs), .o_data_en(rep_de)
    );

    algo_yuv422_to_yuv444_p #(.DW(8), .Y_UPPER(1), .CB_FIRST(1), .INTERP(1)) u_int (
        .clk(clk), .rst(rst), .i_vs(i_vs), .i_hs(i_hs), .i_data_en(i_data_en), .i_q(i_q),
        .o_y(int_y), .o_cb(int_cb), .o_cr(int_cr), .o_vs(int_vs), .o_hs(int_hs), .o_data_en(int_de)
    );

    algo_yuv422_to_yuv444_p #(.DW(10), .Y_UPPER(0), .CB_FIRST(0), .INTERP(1)) u_w10 (
        .clk(clk), .rst(rst), .i_vs(i_vs), .i_hs(i_hs), .i_data_en(i_data_en), .i_q(i_q10),
        .o_y(w10_y), .o_cb(w10_cb), .o_cr(w10_cr), .o_vs(w10_vs), .o_hs(w10_hs), .o_data_en(w10_de)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rep_de) begin
            rep_q.push_back({rep_y, rep_cb, rep_cr});
            rep_cyc.push_back(cyc);
            rep_sync.push_back({rep_vs, rep_hs});
        end
        if (int_de) int_q.push_back({int_y, int_cb, int_cr});
        if (w10_de) w10_q.push_back({w10_y, w10_cb, w10_cr});
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rep_q.delete();
        int_q.delete();
        w10_q.delete();
        rep_cyc.delete();
        rep_sync.delete();
    endtask

    task automatic send_line(input logic [19:0] b[8], input int n, output int start_cyc);
        start_cyc = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start_cyc = cyc;
            i_data_en = 1'b1;
            i_q       = b[i][15:0];
            i_q10     = b[i];
        end
        @(posedge clk);
        #1;
        i_data_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rep_y, rep_cb, rep_cr, rep_vs, rep_hs, rep_de} !== 27'd0) begin
            bad++; $display("FAIL reset_rep got=%h want=0", {rep_y, rep_cb, rep_cr, rep_vs, rep_hs, rep_de});
        end
        total++;
        if ({int_y, int_cb, int_cr, int_vs, int_hs, int_de} !== 27'd0) begin
            bad++; $display("FAIL reset_int got=%h want=0", {int_y, int_cb, int_cr, int_vs, int_hs, int_de});
        end
        total++;
        if ({w10_y, w10_cb, w10_cr, w10_vs, w10_hs, w10_de} !== 33'd0) begin
            bad++; $display("FAIL reset_w10 got=%h want=0", {w10_y, w10_cb, w10_cr, w10_vs, w10_hs, w10_de});
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_replicate();
        logic [19:0] b[8];
        logic [23:0] exp_px[4];
        int st;
        b      = '{20'h01080, 20'h02090, 20'h030A0, 20'h040B0, 20'h0, 20'h0, 20'h0, 20'h0};
        exp_px = '{24'h108090, 24'h208090, 24'h30A0B0, 24'h40A0B0};
        clear_q();
        send_line(b, 4, st);
        idle(6);
        total++;
        if (rep_q.size() !== 4) begin
            bad++; $display("FAIL repl_count got=%0d want=4", rep_q.size());
        end
        for (int i = 0; i < 4 && i < rep_q.size(); i++) begin
            total++;
            if (rep_q[i] !== exp_px[i]) begin
                bad++; $display("FAIL repl_px%0d got=%h want=%h", i, rep_q[i], exp_px[i]);
            end
        end
        if (rep_cyc.size() == 4) begin
            total++;
            if (rep_cyc[0] - st !== 4) begin
                bad++; $display("FAIL repl_latency got=%0d want=4", rep_cyc[0] - st);
            end
            total++;
            if (rep_cyc[3] - st !== 7) begin
                bad++; $display("FAIL repl_last_cycle got=%0d want=7", rep_cyc[3] - st);
            end
        end
        total++;
        if ({rep_de, rep_y, rep_cb, rep_cr} !== {1'b0, 24'h40A0B0}) begin
            bad++; $display("FAIL repl_hold got=%h want=%h", {rep_de, rep_y, rep_cb, rep_cr}, {1'b0, 24'h40A0B0});
        end
    endtask

    task automatic test_interp();
        logic [19:0] b[8];
        logic [23:0] exp_px[4];
        int st;
        b      = '{20'h01080, 20'h02090, 20'h030A0, 20'h040B0, 20'h0, 20'h0, 20'h0, 20'h0};
        exp_px = '{24'h108090, 24'h2090A0, 24'h30A0B0, 24'h40A0B0};
        clear_q();
        send_line(b, 4, st);
        idle(6);
        total++;
        if (int_q.size() !== 4) begin
            bad++; $display("FAIL interp_count got=%0d want=4", int_q.size());
        end
        for (int i = 0; i < 4 && i < int_q.size(); i++) begin
            total++;
            if (int_q[i] !== exp_px[i]) begin
                bad++; $display("FAIL interp_px%0d got=%h want=%h", i, int_q[i], exp_px[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [19:0] b[8];
        int st;
        b = '{20'h01101, 20'h01210, 20'h01302, 20'h01420, 20'h0, 20'h0, 20'h0, 20'h0};
        clear_q();
        send_line(b, 4, st);
        idle(6);
        total++;
        if (int_q.size() < 2 || int_q[1] !== 24'h120218) begin
            bad++; $display("FAIL round_px1 got=%h want=%h", (int_q.size() > 1) ? int_q[1] : 24'hx, 24'h120218);
        end
    endtask

    task automatic test_odd_line();
        logic [19:0] b[8];
        logic [23:0] exp_int[6];
        int st;
        b       = '{20'h01080, 20'h02090, 20'h030A0, 20'h040B0, 20'h050C0, 20'h0, 20'h0, 20'h0};
        exp_int = '{24'h108090, 24'h2090A0, 24'h30A0B0, 24'h40A0B0, 24'h50C0B0, 24'h773380};
        clear_q();
        send_line(b, 5, st);
        idle(3);
        b[0] = 20'h07733;
        send_line(b, 1, st);
        idle(6);
        total++;
        if (int_q.size() !== 6) begin
            bad++; $display("FAIL odd_count got=%0d want=6", int_q.size());
        end
        for (int i = 0; i < 6 && i < int_q.size(); i++) begin
            total++;
            if (int_q[i] !== exp_int[i]) begin
                bad++; $display("FAIL odd_int_px%0d got=%h want=%h", i, int_q[i], exp_int[i]);
            end
        end
        total++;
        if (rep_q.size() !== 6 || rep_q[4] !== 24'h50C0B0 || rep_q[5] !== 24'h773380) begin
            bad++; $display("FAIL odd_rep_tail got=%h,%h want=50c0b0,773380",
                            (rep_q.size() > 4) ? rep_q[4] : 24'hx, (rep_q.size() > 5) ? rep_q[5] : 24'hx);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] a[8];
        logic [19:0] b[8];
        logic [23:0] exp_int[7];
        logic [23:0] exp_rep[7];
        int st;
        a       = '{20'h01080, 20'h02090, 20'h030A0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0};
        b       = '{20'h05011, 20'h06022, 20'h07033, 20'h08044, 20'h0, 20'h0, 20'h0, 20'h0};
        exp_int = '{24'h108090, 24'h208090, 24'h30A090, 24'h501122, 24'h602233, 24'h703344, 24'h803344};
        exp_rep = '{24'h108090, 24'h208090, 24'h30A090, 24'h501122, 24'h601122, 24'h703344, 24'h803344};
        clear_q();
        send_line(a, 3, st);
        send_line(b, 4, st);
        idle(6);
        total++;
        if (int_q.size() !== 7 || rep_q.size() !== 7) begin
            bad++; $display("FAIL b2b_count got=%0d,%0d want=7,7", int_q.size(), rep_q.size());
        end
        for (int i = 0; i < 7 && i < int_q.size() && i < rep_q.size(); i++) begin
            total++;
            if (int_q[i] !== exp_int[i]) begin
                bad++; $display("FAIL b2b_int_px%0d got=%h want=%h", i, int_q[i], exp_int[i]);
            end
            total++;
            if (rep_q[i] !== exp_rep[i]) begin
                bad++; $display("FAIL b2b_rep_px%0d got=%h want=%h", i, rep_q[i], exp_rep[i]);
            end
        end
    endtask

    task automatic test_order_w10();
        logic [19:0] b[8];
        logic [29:0] exp_px[5];
        int st;
        b      = '{20'hFFC01, 20'h40002, 20'hFFC03, 20'h80004, 20'h0, 20'h0, 20'h0, 20'h0};
        exp_px = '{{10'h001, 10'h100, 10'h3FF}, {10'h002, 10'h180, 10'h3FF},
                   {10'h003, 10'h200, 10'h3FF}, {10'h004, 10'h200, 10'h3FF},
                   {10'h3FF, 10'h200, 10'h055}};
        clear_q();
        send_line(b, 4, st);
        idle(3);
        b[0] = 20'h157FF;
        send_line(b, 1, st);
        idle(6);
        total++;
        if (w10_q.size() !== 5) begin
            bad++; $display("FAIL w10_count got=%0d want=5", w10_q.size());
        end
        for (int i = 0; i < 5 && i < w10_q.size(); i++) begin
            total++;
            if (w10_q[i] !== exp_px[i]) begin
                bad++; $display("FAIL w10_px%0d got=%h want=%h", i, w10_q[i], exp_px[i]);
            end
        end
    endtask

    task automatic test_reset_midline();
        logic [19:0] b[8];
        logic [23:0] exp_px[4];
        logic [1:0]  exp_sync[4];
        int st;
        b        = '{20'h01080, 20'h02090, 20'h030A0, 20'h040B0, 20'h0, 20'h0, 20'h0, 20'h0};
        exp_px   = '{24'h108090, 24'h208090, 24'h30A0B0, 24'h40A0B0};
        exp_sync = '{2'b01, 2'b10, 2'b00, 2'b00};
        i_hs = 1'b1;
        idle(5);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            i_data_en = 1'b1;
            i_q       = 16'hA5C3 + 16'(i);
            i_q10     = 20'h5A5A5;
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({rep_y, rep_cb, rep_cr, rep_hs, rep_vs, rep_de} !== 27'd0) begin
            bad++; $display("FAIL midrst_rep got=%h want=0", {rep_y, rep_cb, rep_cr, rep_hs, rep_vs, rep_de});
        end
        total++;
        if ({w10_y, w10_cb, w10_cr, w10_hs} !== 31'd0) begin
            bad++; $display("FAIL midrst_w10 got=%h want=0", {w10_y, w10_cb, w10_cr, w10_hs});
        end
        i_data_en = 1'b0;
        i_hs      = 1'b0;
        idle(2);
        rst = 1'b0;
        clear_q();
        idle(1);
        st = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) st = cyc;
            i_data_en = 1'b1;
            i_q       = b[i][15:0];
            i_q10     = b[i];
            i_hs      = (i == 0);
            i_vs      = (i == 1);
        end
        @(posedge clk);
        #1;
        i_data_en = 1'b0;
        i_hs      = 1'b0;
        i_vs      = 1'b0;
        idle(6);
        total++;
        if (rep_q.size() !== 4) begin
            bad++; $display("FAIL midrst_count got=%0d want=4", rep_q.size());
        end
        for (int i = 0; i < 4 && i < rep_q.size(); i++) begin
            total++;
            if (rep_q[i] !== exp_px[i]) begin
                bad++; $display("FAIL midrst_px%0d got=%h want=%h", i, rep_q[i], exp_px[i]);
            end
            total++;
            if (rep_sync[i] !== exp_sync[i]) begin
                bad++; $display("FAIL midrst_sync%0d got=%b want=%b", i, rep_sync[i], exp_sync[i]);
            end
        end
        total++;
        if (rep_cyc.size() < 1 || rep_cyc[0] - st !== 4) begin
            bad++; $display("FAIL midrst_latency got=%0d want=4", (rep_cyc.size() > 0) ? rep_cyc[0] - st : -1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        i_vs      = 1'b0;
        i_hs      = 1'b0;
        i_data_en = 1'b0;
        i_q       = '0;
        i_q10     = '0;
        test_reset();
        test_replicate();
        test_interp();
        test_rounding();
        test_odd_line();
        test_back_to_back();
        test_order_w10();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
